// File: rtl/prog_loader_pkg.sv
// Shared types for the program loader: FSM encoding and word geometry.
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Little-endian byte packer: each accepted byte lands in the next lane of a 32-bit word.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [7:0]  in_byte,
    input  logic        in_fire,
    output logic [31:0] word,
    output logic        word_full
);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;

    // Next lane index and assembly contents.
    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clear) begin
            idx_d  = 2'd0;
            word_d = 32'd0;
        end else if (in_fire) begin
            case (idx_q)
                2'd0:    word_d[7:0]   = in_byte;
                2'd1:    word_d[15:8]  = in_byte;
                2'd2:    word_d[23:16] = in_byte;
                2'd3:    word_d[31:24] = in_byte;
                default: word_d        = word_q;
            endcase
            idx_d = idx_q + 2'd1;
        end else begin
            idx_d  = idx_q;
            word_d = word_q;
        end
    end

    // Lane index and assembly register.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= 2'd0;
            word_q <= 32'd0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    assign word      = word_q;
    assign word_full = in_fire && (idx_q == LAST_LANE);

endmodule

// File: rtl/prog_loader.sv
// Program loader: packs UART bytes into words, writes them to instruction memory,
// and holds the core in reset until the requested number of words is written.
module prog_loader
    import loader_pkg::*;
#(
    parameter int unsigned WIDTH     = 7,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] num_words,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [WIDTH-1:0] words_loaded,
    output logic             busy,
    output logic             core_hold,
    output logic             done
);

    loader_state_t    state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] words_loaded_q, words_loaded_d;
    logic             done_q, done_d;
    logic             core_hold_q, core_hold_d;
    logic [WIDTH-1:0] words_inc;
    logic             start_ok;
    logic             fire;
    logic             word_full;
    logic [31:0]      word;

    assign start_ok  = start && ((state_q == IDLE) || (state_q == DONE));
    assign fire      = rx_valid && (state_q == RECV);
    assign words_inc = words_loaded_q + WIDTH'(1);

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_ok),
        .in_byte   (rx_data),
        .in_fire   (fire),
        .word      (word),
        .word_full (word_full)
    );

    // Load sequencing; done/core_hold trail the DONE state by one cycle.
    always_comb begin
        state_d        = state_q;
        n_d            = n_q;
        words_loaded_d = words_loaded_q;
        done_d         = (state_q == DONE);
        core_hold_d    = (state_q != DONE);
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    words_loaded_d = '0;
                    if (num_words != '0) begin
                        n_d     = num_words;
                        state_d = RECV;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            RECV: begin
                if (word_full) begin
                    state_d = WRITE;
                end else begin
                    state_d = RECV;
                end
            end
            WRITE: begin
                words_loaded_d = words_inc;
                if (words_inc == n_q) begin
                    state_d = DONE;
                end else begin
                    state_d = RECV;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            n_q            <= '0;
            words_loaded_q <= '0;
            done_q         <= 1'b0;
            core_hold_q    <= 1'b1;
        end else begin
            state_q        <= state_d;
            n_q            <= n_d;
            words_loaded_q <= words_loaded_d;
            done_q         <= done_d;
            core_hold_q    <= core_hold_d;
        end
    end

    assign rx_ready     = (state_q == RECV);
    assign mem_we       = (state_q == WRITE);
    assign busy         = (state_q == RECV) || (state_q == WRITE);
    assign mem_addr     = BASE_ADDR + 32'({words_loaded_q, 2'b00});
    assign mem_wdata    = word;
    assign words_loaded = words_loaded_q;
    assign done         = done_q;
    assign core_hold    = core_hold_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: two instances (base 0x0 and 0x100) share stimulus
// and are checked every cycle against a transaction-level model of the load.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  num_words = 7'd0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;

    logic        rx_ready0, mem_we0, busy0, core_hold0, done0;
    logic [31:0] mem_addr0, mem_wdata0;
    logic [6:0]  words_loaded0;
    logic        rx_ready1, mem_we1, busy1, core_hold1, done1;
    logic [31:0] mem_addr1, mem_wdata1;
    logic [6:0]  words_loaded1;

    prog_loader #(.WIDTH(7), .BASE_ADDR(32'h0000_0000)) dut0 (
        .clk(clk), .rst(rst), .start(start), .num_words(num_words),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready0),
        .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .words_loaded(words_loaded0), .busy(busy0), .core_hold(core_hold0), .done(done0)
    );

    prog_loader #(.WIDTH(7), .BASE_ADDR(32'h0000_0100)) dut1 (
        .clk(clk), .rst(rst), .start(start), .num_words(num_words),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready1),
        .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .words_loaded(words_loaded1), .busy(busy1), .core_hold(core_hold1), .done(done1)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;
    bit xfer_pend = 1'b0;
    int acc_cyc = 0;

    // Behavioural model: a load is active, bytes collect in a queue, every 4th byte
    // produces one write cycle; done shows one cycle after the load has finished.
    bit          m_active   = 1'b0;
    bit          m_writing  = 1'b0;
    bit          m_finished = 1'b0;
    bit          m_done     = 1'b0;
    int          m_count    = 0;
    int          m_n        = 0;
    logic [31:0] m_word     = 32'd0;
    logic [7:0]  byte_q[$];

    logic [7:0]  bytes [0:511];
    logic [31:0] wr_addr0 [0:255];
    logic [31:0] wr_addr1 [0:255];
    logic [31:0] wr_data0 [0:255];
    int          wr_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit was_finished;
        cyc++;
        was_finished = m_finished;
        if (rst) begin
            m_active = 1'b0; m_writing = 1'b0; m_finished = 1'b0;
            m_count = 0; m_word = 32'd0; byte_q.delete();
        end else if (!m_active && start) begin
            byte_q.delete();
            m_count = 0;
            if (num_words != 7'd0) begin
                m_active = 1'b1; m_n = int'(num_words); m_finished = 1'b0;
            end else begin
                m_finished = 1'b1;
            end
        end else if (m_writing) begin
            m_writing = 1'b0;
            m_count++;
            if (m_count == m_n) begin
                m_active = 1'b0; m_finished = 1'b1;
            end
        end else if (m_active && rx_valid) begin
            byte_q.push_back(rx_data);
            if (byte_q.size() == 4) begin
                m_word = {byte_q[3], byte_q[2], byte_q[1], byte_q[0]};
                m_writing = 1'b1;
                byte_q.delete();
            end
        end
        m_done = rst ? 1'b0 : was_finished;
    endtask

    task automatic compare();
        xfer_pend = rx_valid && rx_ready0;
        chk("rx_ready0", 32'(rx_ready0), 32'(m_active && !m_writing));
        chk("rx_ready1", 32'(rx_ready1), 32'(m_active && !m_writing));
        chk("mem_we0", 32'(mem_we0), 32'(m_writing));
        chk("mem_we1", 32'(mem_we1), 32'(m_writing));
        chk("busy0", 32'(busy0), 32'(m_active));
        chk("busy1", 32'(busy1), 32'(m_active));
        chk("done0", 32'(done0), 32'(m_done));
        chk("done1", 32'(done1), 32'(m_done));
        chk("core_hold0", 32'(core_hold0), 32'(!m_done));
        chk("core_hold1", 32'(core_hold1), 32'(!m_done));
        chk("words_loaded0", 32'(words_loaded0), 32'(m_count));
        chk("words_loaded1", 32'(words_loaded1), 32'(m_count));
        if (m_writing) begin
            chk("mem_addr0", mem_addr0, 32'(m_count * 4));
            chk("mem_addr1", mem_addr1, 32'h100 + 32'(m_count * 4));
            chk("mem_wdata0", mem_wdata0, m_word);
            chk("mem_wdata1", mem_wdata1, m_word);
        end
        if (mem_we0 && wr_n < 256) begin
            wr_addr0[wr_n] = mem_addr0;
            wr_addr1[wr_n] = mem_addr1;
            wr_data0[wr_n] = mem_wdata0;
            wr_n++;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) compare();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [6:0] n);
        start = 1'b1;
        num_words = n;
        tick();
        start = 1'b0;
    endtask

    // Source holds each byte until accepted; gap is the percent chance of idling.
    task automatic feed(input int count, input int gap, input int start_at);
        int idx = 0;
        int k = 0;
        rx_valid = 1'b0;
        while (idx < count && k < 4000) begin
            if (!rx_valid) begin
                rx_data  = bytes[idx];
                rx_valid = ($urandom_range(99) >= gap);
            end
            start = (k == start_at);
            if (start) num_words = 7'd5;
            tick();
            k++;
            if (xfer_pend) begin
                idx++;
                acc_cyc = cyc;
                rx_valid = 1'b0;
            end
        end
        rx_valid = 1'b0;
        start = 1'b0;
        chk("feed_bytes_accepted", 32'(idx), 32'(count));
    endtask

    task automatic wait_done(output int t);
        int k = 0;
        while (!done0 && k < 2000) begin
            tick();
            k++;
        end
        chk("done_reached", 32'(done0), 32'd1);
        t = cyc;
    endtask

    initial begin
        int td;
        // Reset and idle
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        chk("reset_core_hold", 32'(core_hold0), 32'd1);
        chk("reset_addr1", mem_addr1, 32'h0000_0100);
        chk("reset_wdata", mem_wdata0, 32'd0);
        rx_valid = 1'b1;
        rx_data = 8'h5A;
        repeat (3) tick();
        chk("idle_rx_ready", 32'(rx_ready0), 32'd0);
        rx_valid = 1'b0;
        chk("idle_no_write", 32'(wr_n), 32'd0);

        // Single word
        bytes[0] = 8'h13; bytes[1] = 8'h00; bytes[2] = 8'h00; bytes[3] = 8'h00;
        do_start(7'd1);
        feed(4, 0, -1);
        wait_done(td);
        chk("single_done_latency", 32'(td - acc_cyc), 32'd2);
        chk("single_nwrites", 32'(wr_n), 32'd1);
        chk("single_addr0", wr_addr0[0], 32'h0);
        chk("single_addr1", wr_addr1[0], 32'h100);
        chk("single_data", wr_data0[0], 32'h0000_0013);
        chk("model_word_single", m_word, 32'h0000_0013);
        chk("single_core_hold", 32'(core_hold0), 32'd0);

        // Three words with random gaps
        wr_n = 0;
        for (int i = 0; i < 12; i++) bytes[i] = 8'(i + 1);
        do_start(7'd3);
        feed(12, 40, -1);
        wait_done(td);
        chk("three_nwrites", 32'(wr_n), 32'd3);
        chk("three_a0", wr_addr0[0], 32'h0);
        chk("three_d0", wr_data0[0], 32'h0403_0201);
        chk("three_a1", wr_addr0[1], 32'h4);
        chk("three_d1", wr_data0[1], 32'h0807_0605);
        chk("three_a2", wr_addr0[2], 32'h8);
        chk("three_d2", wr_data0[2], 32'h0C0B_0A09);
        chk("three_words_loaded", 32'(words_loaded0), 32'd3);

        // Zero-length from IDLE, then a start pulse during a load
        rst = 1'b1; tick(); rst = 1'b0;
        wr_n = 0;
        do_start(7'd0);
        tick();
        chk("zero_done", 32'(done0), 32'd1);
        chk("zero_nwrites", 32'(wr_n), 32'd0);
        for (int i = 0; i < 8; i++) bytes[i] = 8'($urandom_range(255));
        do_start(7'd2);
        feed(8, 20, 5);
        wait_done(td);
        chk("ignored_start_nwrites", 32'(wr_n), 32'd2);
        chk("ignored_start_count", 32'(words_loaded0), 32'd2);

        // Reset in the middle of an N=4 load
        for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom_range(255));
        do_start(7'd4);
        feed(6, 0, -1);
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        chk("midrst_busy", 32'(busy0), 32'd0);
        chk("midrst_count", 32'(words_loaded0), 32'd0);
        chk("midrst_hold", 32'(core_hold0), 32'd1);
        wr_n = 0;
        bytes[0] = 8'hAA; bytes[1] = 8'hBB; bytes[2] = 8'hCC; bytes[3] = 8'hDD;
        do_start(7'd1);
        feed(4, 0, -1);
        wait_done(td);
        chk("midrst_addr", wr_addr0[0], 32'h0);
        chk("midrst_data", wr_data0[0], 32'hDDCC_BBAA);

        // Maximum count, then restart from DONE
        wr_n = 0;
        for (int i = 0; i < 508; i++) bytes[i] = 8'($urandom_range(255));
        do_start(7'd127);
        feed(508, 10, -1);
        wait_done(td);
        chk("max_nwrites", 32'(wr_n), 32'd127);
        chk("max_last_addr1", wr_addr1[126], 32'h0000_02F8);
        chk("max_last_addr0", wr_addr0[126], 32'h0000_01F8);
        chk("max_count", 32'(words_loaded0), 32'd127);
        wr_n = 0;
        for (int i = 0; i < 4; i++) bytes[i] = 8'($urandom_range(255));
        do_start(7'd1);
        chk("restart_done_held", 32'(done0), 32'd1);
        tick();
        chk("restart_done_drop", 32'(done0), 32'd0);
        feed(4, 30, -1);
        wait_done(td);
        chk("restart_addr1", wr_addr1[0], 32'h0000_0100);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Upstream feeder for the word counter in the program-load path. It accepts a byte stream from the UART receiver and packs each group of four bytes into a 32-bit little-endian word. Each word is written to instruction memory at consecutive word addresses, and the loader stops after a programmed number of words. While loading, it holds the core in reset and reports progress and completion.

Parameters:
WIDTH, 7, width of word-count fields (num_words, words_loaded); maximum load is 2^WIDTH-1 words
BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be 4-byte aligned

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a load; sampled only in IDLE and DONE
num_words  in  WIDTH  number of 32-bit words to load; sampled with start
rx_data  in  8  incoming byte
rx_valid  in  1  rx_data valid; source holds the byte until accepted
rx_ready  out  1  loader can accept a byte; a transfer occurs when rx_valid && rx_ready
mem_we  out  1  instruction-memory write strobe, one cycle per word
mem_addr  out  32  byte address of the write: BASE_ADDR + 4*word index
mem_wdata  out  32  assembled word
words_loaded  out  WIDTH  words written so far in the current load
busy  out  1  high in RECV and WRITE
core_hold  out  1  high from reset until the load completes; keeps the CPU in reset
done  out  1  high in DONE; held until the next start

Behaviour:
- Reset values (applied on any rst edge, including mid-load): state=IDLE, rx_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, words_loaded=0, busy=0, done=0, core_hold=1, byte index=0, assembly register=0.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - start with num_words!=0: latch N=num_words, clear words_loaded and byte index, go to RECV.
  - start with num_words==0: go directly to DONE with no writes.
- RECV:
  - rx_ready=1.
  - On each transfer, rx_data is placed in byte lane idx (bits 8*idx+7:8*idx) and idx increments.
  - The transfer with idx==3 moves the FSM to WRITE and returns idx to 0.
  - rx_valid with no transfer has no effect.
- WRITE (exactly one cycle):
  - rx_ready=0, mem_we=1, mem_addr=BASE_ADDR+4*words_loaded, mem_wdata=assembled word.
  - words_loaded increments at the end of the cycle.
  - If the new count equals N, go to DONE; otherwise go to RECV.
- DONE:
  - done=1, core_hold=0, rx_ready=0.
  - Bytes arriving here are not accepted; the source stalls.
  - start restarts the load exactly as from IDLE, and done drops the cycle after start.
- start in RECV/WRITE: ignored.
- Latency:
  - 4th byte accepted at edge t: mem_we high in cycle t..t+1.
  - For the final word, done and core_hold=0 are registered at edge t+2.
- Throughput: at most 4 bytes per 5 cycles (one bubble per word in WRITE).
- Arithmetic: mem_addr is 32-bit, computed as BASE_ADDR + {words_loaded,2'b00}, zero-extended with no wrap. words_loaded never exceeds N.
- Outputs are registered or decoded only from state; there is no combinational path from rx_valid to rx_ready.

Decomposition:
- Shared package loader_pkg:
  - typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} loader_state_t
  - localparam BYTES_PER_WORD = 4
- Sub-module byte_packer:
  - Contents: 2-bit lane index and 32-bit shift/assembly register.
  - Inputs: clk, rst, clear, in_byte, in_fire.
  - Outputs: word, word_full.
  - The FSM stays in prog_loader.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> all outputs at reset values, core_hold=1; rx_valid=1 with start=0 -> rx_ready stays 0, no mem_we.
- Single word: start, num_words=1, bytes 0x13,0x00,0x00,0x00 back-to-back -> one mem_we with addr 0x0, data 0x00000013; done=1 and core_hold=0 two cycles after the 4th byte.
- Three words with random rx_valid gaps: bytes 0x01..0x0C, N=3 -> writes (0x0,0x04030201), (0x4,0x08070605), (0x8,0x0C0B0A09); words_loaded sequence 1,2,3; rx_ready=0 in each WRITE cycle.
- Zero-length and ignored start: num_words=0 -> DONE next cycle, no mem_we; start pulsed mid-load with N=2 -> load completes with exactly 2 writes.
- Reset mid-operation: rst after 6 bytes of an N=4 load -> outputs back to reset values; a fresh N=1 load then writes addr 0x0 with no leftover bytes in the word.
- Restart from DONE and max count: WIDTH=7, N=127 with BASE_ADDR=0x100 -> last write addr 0x100+4*126=0x2F8; then start with N=1 -> done drops, and a new write lands at 0x100.
